// File: rtl/crc_parity_codec.sv
// rtl/crc_parity_codec.sv - serial CRC + even-parity encoder / single-error-correcting checker
module crc_parity_codec #(
  parameter int DATA_W = 11,
  parameter int CRC_W = 4,
  parameter logic [CRC_W-1:0] POLY = 4'b0011,
  parameter logic [CRC_W-1:0] INIT = '0,
  localparam int N = DATA_W + CRC_W,
  localparam int CW = N + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          mode,
  input  logic [CW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_data,
  output logic [1:0]    out_status,
  output logic          busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, CALC, SEARCH, DONE} state_t;

  state_t state, state_n;

  logic [CW-1:0]     word;
  logic [CW-1:0]     mask;
  logic [DATA_W-1:0] dsh;
  logic              md;
  logic [CRC_W-1:0]  crc, crc_n, syn, syn_n, r, r_n;
  logic [CNT_W-1:0]  cnt;
  logic              fb, pe, last;

  always_comb begin
    fb    = crc[CRC_W-1] ^ dsh[DATA_W-1];
    crc_n = {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    syn_n = crc_n ^ word[CRC_W:1];
    pe    = ^word;
    // r tracks x^p mod g, the syndrome a single error at position p would produce
    r_n   = {r[CRC_W-2:0], 1'b0} ^ (r[CRC_W-1] ? POLY : '0);
    last  = (cnt == CNT_W'(DATA_W - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = reset;
        busy     = 1'b0;
        if (in_valid) state_n = CALC;
      end
      CALC: begin
        if (last) begin
          if (md && (syn_n != '0) && pe) state_n = SEARCH;
          else                           state_n = DONE;
        end
      end
      SEARCH: begin
        if ((r == syn) || mask[CW-1]) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word       <= '0;
      mask       <= '0;
      dsh        <= '0;
      md         <= 1'b0;
      crc        <= '0;
      syn        <= '0;
      r          <= '0;
      cnt        <= '0;
      out_data   <= '0;
      out_status <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            word <= in_data;
            dsh  <= in_data[CW-1 -: DATA_W];
            md   <= mode;
            crc  <= INIT;
            cnt  <= '0;
          end
        end
        CALC: begin
          crc <= crc_n;
          dsh <= {dsh[DATA_W-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (last) begin
            if (!md) begin
              out_data   <= {word[CW-1 -: DATA_W], crc_n, ^{word[CW-1 -: DATA_W], crc_n}};
              out_status <= 2'b00;
            end else if (syn_n == '0) begin
              out_data   <= word ^ {{(CW-1){1'b0}}, pe};
              out_status <= {1'b0, pe};
            end else if (!pe) begin
              out_data   <= word;
              out_status <= 2'b10;
            end else begin
              syn  <= syn_n;
              r    <= CRC_W'(1);
              mask <= CW'(2);
            end
          end
        end
        SEARCH: begin
          if (r == syn) begin
            out_data   <= word ^ mask;
            out_status <= 2'b01;
          end else if (mask[CW-1]) begin
            out_data   <= word;
            out_status <= 2'b10;
          end else begin
            r    <= r_n;
            mask <= {mask[CW-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_parity_codec.sv
// tb/tb_crc_parity_codec.sv - scoreboard bench for crc_parity_codec
module tb_crc_parity_codec;

  logic        clk = 1'b0;
  logic        reset, in_valid, mode, out_ready;
  logic        in_ready, out_valid, busy;
  logic [15:0] in_data, out_data;
  logic [1:0]  out_status;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  status;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  crc_parity_codec #(
    .DATA_W(11),
    .CRC_W(4),
    .POLY(4'b0011),
    .INIT(4'b0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mode(mode),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_status(out_status),
    .busy(busy)
  );

  // Remainder of d(x)*x^4 divided by x^4+x+1, by polynomial long division
  function automatic logic [3:0] ref_crc(input logic [10:0] d);
    logic [14:0] v;
    v = {d, 4'b0000};
    for (int i = 14; i >= 4; i--)
      if (v[i]) v[i -: 5] = v[i -: 5] ^ 5'b10011;
    return v[3:0];
  endfunction

  function automatic logic [15:0] ref_enc(input logic [10:0] d);
    logic [3:0] c;
    c = ref_crc(d);
    return {d, c, ^{d, c}};
  endfunction

  task automatic run_word(input logic [15:0] w, input logic m, input logic [15:0] ed,
                          input logic [1:0] es, input int el, input int hold, input string name);
    exp_t e;
    exp_t got;
    int lat;
    e.data = ed;
    e.status = es;
    e.lat = el;
    sb.push_back(e);
    @(negedge clk);
    in_data = w;
    mode = m;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s in_ready_idle: got %b want 1", name, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    mode = ~m;
    in_data = ~w;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    got = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s timeout: out_valid got %b want 1", name, out_valid);
    end
    checks++;
    if (out_data !== got.data) begin
      failures++;
      $display("FAIL %s out_data: got %h want %h", name, out_data, got.data);
    end
    checks++;
    if (out_status !== got.status) begin
      failures++;
      $display("FAIL %s out_status: got %b want %b", name, out_status, got.status);
    end
    checks++;
    if (lat !== got.lat) begin
      failures++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, got.lat);
    end
    checks++;
    if ({busy, in_ready} !== 2'b10) begin
      failures++;
      $display("FAIL %s done_flags: busy,in_ready got %b want 10", name, {busy, in_ready});
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, in_ready, out_data} !== {1'b1, 1'b0, got.data}) begin
        failures++;
        $display("FAIL %s hold_%0d: valid,ready,data got %b%b %h want 10 %h",
                 name, i, out_valid, in_ready, out_data, got.data);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      failures++;
      $display("FAIL %s after_handshake: valid,ready,busy got %b want 010",
               name, {out_valid, in_ready, busy});
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    in_valid = 1'b0;
    mode = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    #12;
    checks++;
    if ({in_ready, out_valid, busy, out_status, out_data} !== 21'd0) begin
      failures++;
      $display("FAIL reset_state: ready,valid,busy,status,data got %b%b%b %b %h want 000 00 0000",
               in_ready, out_valid, busy, out_status, out_data);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_encode;
    logic [10:0] d;
    run_word({11'b10000000000, 5'b00000}, 1'b0, 16'h8013, 2'b00, 11, 0, "encode_msb");
    run_word({11'b10000000000, 5'b11111}, 1'b0, 16'h8013, 2'b00, 11, 0, "encode_ignore_low");
    run_word(16'h0000, 1'b0, 16'h0000, 2'b00, 11, 0, "encode_zero");
    for (int i = 0; i < 4; i++) begin
      d = 11'($urandom);
      run_word({d, 5'($urandom)}, 1'b0, ref_enc(d), 2'b00, 11, 0, "encode_rand");
    end
  endtask

  task automatic test_check;
    run_word(16'h8013, 1'b1, 16'h8013, 2'b00, 11, 0, "check_clean");
    run_word(16'h0013, 1'b1, 16'h8013, 2'b01, 26, 0, "check_data_msb");
    run_word(16'h8012, 1'b1, 16'h8013, 2'b01, 11, 0, "check_parity_bit");
    run_word(16'h8015, 1'b1, 16'h8015, 2'b10, 11, 0, "check_double");
  endtask

  task automatic test_single_error;
    logic [15:0] cw;
    int b;
    for (int i = 0; i < 16; i++) begin
      cw = ref_enc(11'($urandom));
      b = i;
      run_word(cw ^ (16'h0001 << b), 1'b1, cw, 2'b01, (b == 0) ? 11 : 11 + b, 0, "single_err");
    end
  endtask

  task automatic test_double_error;
    logic [15:0] cw, bad;
    int b1, b2;
    for (int i = 0; i < 4; i++) begin
      cw = ref_enc(11'($urandom));
      b1 = $urandom_range(0, 15);
      b2 = (b1 + $urandom_range(1, 15)) % 16;
      bad = cw ^ (16'h0001 << b1) ^ (16'h0001 << b2);
      run_word(bad, 1'b1, bad, 2'b10, 11, 0, "double_err");
    end
  endtask

  task automatic test_backpressure;
    run_word(16'h0013, 1'b1, 16'h8013, 2'b01, 26, 5, "backpressure_search");
    run_word({11'b10000000000, 5'b00000}, 1'b0, 16'h8013, 2'b00, 11, 5, "backpressure_encode");
  endtask

  task automatic test_reset_mid;
    logic seen;
    @(negedge clk);
    in_data = ref_enc(11'h5a5);
    mode = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_busy: got %b want 1", busy);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, busy, out_data} !== 19'd0) begin
      failures++;
      $display("FAIL reset_mid_async: valid,ready,busy,data got %b%b%b %h want 000 0000",
               out_valid, in_ready, busy, out_data);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({in_ready, busy} !== 2'b10) begin
      failures++;
      $display("FAIL reset_mid_idle: ready,busy got %b want 10", {in_ready, busy});
    end
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_no_output: out_valid seen %b want 0", seen);
    end
    run_word(16'h0013, 1'b1, 16'h8013, 2'b01, 26, 0, "after_reset");
  endtask

  task automatic test_back_to_back;
    logic [15:0] cw;
    int b;
    for (int i = 0; i < 6; i++) begin
      cw = ref_enc(11'($urandom));
      if (i % 2 == 0) begin
        run_word({cw[15:5], 5'b0}, 1'b0, cw, 2'b00, 11, 0, "b2b_encode");
      end else begin
        b = $urandom_range(0, 15);
        run_word(cw ^ (16'h0001 << b), 1'b1, cw, 2'b01, (b == 0) ? 11 : 11 + b, 0, "b2b_check");
      end
    end
  endtask

  initial begin
    test_reset();
    test_encode();
    test_check();
    test_single_error();
    test_double_error();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crc_parity_codec.md
Name: crc_parity_codec

Overview:
- Parametrised, serial CRC-plus-parity codec; successor to the fixed 15-bit transmitter/receiver pair.
- Encode mode: appends a CRC and an overall even-parity bit to a data word.
- Check mode: verifies a received codeword, corrects any single-bit error (data, CRC or parity bit) and flags uncorrectable words.
- Sits between the link framing logic and the payload consumer, with valid/ready handshakes on both sides.

Parameters:
- DATA_W, 11, payload width in bits.
- CRC_W, 4, CRC width in bits.
- POLY, 4'b0011, generator polynomial without its implicit x^CRC_W term (default x^4+x+1).
- INIT, 0, initial CRC register value.
- Derived: N = DATA_W+CRC_W; CW = N+1.
- Single-error correction is guaranteed only when POLY is primitive and N <= 2^CRC_W-1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word.
- mode  in  1  0 = encode, 1 = check; sampled on accept.
- in_data  in  CW  encode: data in [CW-1 -: DATA_W], rest ignored; check: full codeword.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  CW  codeword {data, crc, parity}.
- out_status  out  2  00 ok, 01 corrected, 10 uncorrectable, 11 unused.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Codeword layout: [CW-1:CRC_W+1] data, [CRC_W:1] crc, [0] parity.
  - Parity makes the XOR of all CW bits equal 0.
  - Error position index p runs 0..N-1 over {data,crc}, with p=0 at out_data[1].
- Reset, asynchronous while reset=0:
  - State goes to IDLE.
  - out_valid=0, in_ready=0 while reset is asserted, then 1 in IDLE.
  - out_data=0, out_status=00, busy=0.
  - All internal registers clear.
  - Reset mid-operation discards the word in flight; no output is produced for it.
- States: IDLE, CALC, SEARCH, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture in_data and mode, load CRC register with INIT, clear bit counter, go to CALC.
- CALC, one data bit per edge, MSB first:
  - fb = crc[CRC_W-1] ^ bit.
  - crc = (crc<<1) ^ (fb ? POLY : 0).
  - After exactly DATA_W edges, the DATA_W-th edge leaves CALC.
  - Encode exit: out_data = {data, crc, ^{data,crc}}, status 00, go to DONE.
  - Check exit: syndrome S = crc_calc ^ crc_rx; parity error PE = XOR of all CW received bits.
    - S==0, PE==0: status 00, go to DONE.
    - S==0, PE==1: invert bit 0, status 01, go to DONE.
    - S!=0, PE==0: status 10, go to DONE.
    - S!=0, PE==1: r=1, p=0, go to SEARCH.
- SEARCH, one position per edge:
  - If r==S: invert the bit at position p, status 01, go to DONE.
  - Otherwise: r = (r<<1) ^ (r[CRC_W-1] ? POLY : 0), p++.
  - If p reaches N without a match: status 10, go to DONE.
- DONE:
  - out_valid=1; out_data and out_status stay stable until out_valid&out_ready.
  - Handshake edge goes to IDLE.
  - No new accept occurs in the same cycle (in_ready=0 outside IDLE).
- Uncorrectable (status 10): out_data equals the received word unchanged.
- Latency, with out_valid high after edge k counted from the accept edge:
  - Encode, and check with no search: k = DATA_W.
  - Check with search finding position p: k = DATA_W + p + 1.
  - Worst case: DATA_W + N.
- out_ready held high in DONE gives 1 cycle of out_valid.
- out_ready low holds output indefinitely (backpressure).
- in_valid with no handshake has no effect.
- mode changes after accept are ignored.

Test Plan:
- Encode in_data[15:5]=11'b10000000000, mode=0 -> out_data=16'h8013 (crc 1001, parity 1), out_status=00, out_valid after 11 edges.
- Check 16'h8013 -> out_data=16'h8013, status 00, latency 11.
- Check 16'h0013 (data MSB flipped, p=14) -> S=1001, search 15 edges; out_data=16'h8013, status 01, latency 26.
- Check 16'h8012 (parity bit flipped) -> out_data=16'h8013, status 01, latency 11, no SEARCH.
- Check 16'h8015 (two bits flipped) -> status 10, out_data=16'h8015.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE -> out_data stable, in_ready=0.
  - Drop reset to 0 mid-CALC -> out_valid=0 immediately, IDLE with in_ready=1 after release, next word processed correctly.
